// File: rtl/imem_pkg.sv
// Shared constants and FSM state type for the instruction-memory loader.
package imem_pkg;

    localparam int unsigned IMEM_DEPTH = 400;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/imem_byte_ram.sv
// Byte-wide instruction RAM: one synchronous byte write port and a combinational
// big-endian word read assembled from four byte reads, out-of-range bytes read as zero.
module imem_byte_ram
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH = IMEM_DEPTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [31:0]           wadrs,
    input  logic [BYTE_W-1:0]     wbyte,
    input  logic [31:0]           radrs,
    output logic [31:0]           rword
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [BYTE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we && (wadrs < 32'(DEPTH))) begin
            mem[wadrs[AW-1:0]] <= wbyte;
        end
    end

    // 33-bit address sum so a fetch address near 2^32 cannot wrap into range.
    always_comb begin
        logic [32:0] ra;
        rword = '0;
        ra    = '0;
        for (int unsigned i = 0; i < WORD_BYTES; i++) begin
            ra = {1'b0, radrs} + 33'(i);
            if (ra < 33'(DEPTH)) begin
                rword[(WORD_BYTES-1-i)*BYTE_W +: BYTE_W] = mem[ra[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction memory with an in-system loader: host words are accepted over a
// valid/ready handshake and written MSB byte first, one byte per cycle.
module imem_loader
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH = IMEM_DEPTH
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] base_adrs,
    input  logic [31:0] wdata,
    input  logic        wvalid,
    input  logic        wlast,
    output logic        wready,
    output logic        busy,
    output logic        done,
    output logic        err,
    input  logic [31:0] RAdrs,
    output logic [31:0] ITM
);

    state_e            state_q, state_d;
    logic [31:0]       ptr_q, ptr_d;
    logic [31:0]       word_q, word_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              err_q, err_d;

    logic              we;
    logic [31:0]       wadrs;
    logic [BYTE_W-1:0] wbyte;
    logic              fits;

    // Whole word must fit; checked in 33 bits so pointers near 2^32 cannot wrap.
    assign fits  = ({1'b0, ptr_q} + 33'd3) <= (33'(DEPTH) - 33'd1);
    assign wadrs = ptr_q + {30'd0, cnt_q};

    always_comb begin
        unique case (cnt_q)
            2'd0:    wbyte = word_q[31:24];
            2'd1:    wbyte = word_q[23:16];
            2'd2:    wbyte = word_q[15:8];
            default: wbyte = word_q[7:0];
        endcase
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        err_d   = err_q;
        we      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    ptr_d   = base_adrs;
                    err_d   = 1'b0;
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (wvalid) begin
                    if (fits) begin
                        word_d  = wdata;
                        last_d  = wlast;
                        cnt_d   = '0;
                        state_d = WRITE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            WRITE: begin
                we    = 1'b1;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    ptr_d   = ptr_q + 32'd4;
                    state_d = last_q ? DONE : ARMED;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            word_q  <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign wready = (state_q == ARMED);
    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign err    = err_q;

    imem_byte_ram #(
        .DEPTH(DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .wadrs (wadrs),
        .wbyte (wbyte),
        .radrs (RAdrs),
        .rword (ITM)
    );

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a byte-array reference model.
module tb_imem_loader;
    import imem_pkg::*;

    localparam int unsigned D = IMEM_DEPTH;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_adrs = '0;
    logic [31:0] wdata = '0;
    logic        wvalid = 1'b0;
    logic        wlast = 1'b0;
    logic        wready, busy, done, err;
    logic [31:0] RAdrs = '0;
    logic [31:0] ITM;

    imem_loader #(.DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_adrs(base_adrs),
        .wdata(wdata), .wvalid(wvalid), .wlast(wlast), .wready(wready),
        .busy(busy), .done(done), .err(err), .RAdrs(RAdrs), .ITM(ITM)
    );

    always #5 clk = ~clk;

    int unsigned n_chk = 0;
    int unsigned n_fail = 0;

    logic [7:0]  mdl [D];
    logic [31:0] m_ptr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_itm(input logic [31:0] a);
        logic [31:0] r;
        longint unsigned ai;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            ai = longint'(a) + longint'(i);
            if (ai < longint'(D)) r[31-8*i -: 8] = mdl[ai];
        end
        return r;
    endfunction

    task automatic read_chk(input string tag, input logic [31:0] a);
        @(negedge clk);
        RAdrs = a;
        #1 chk(tag, ITM, exp_itm(a));
    endtask

    task automatic do_start(input logic [31:0] b);
        @(negedge clk);
        base_adrs = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        m_ptr = b;
        @(negedge clk);
        chk("start_err", {31'd0, err}, 32'd0);
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_wready", {31'd0, wready}, 32'd1);
    endtask

    // Sends one word from a negedge; poke pulses a stray start during the byte writes.
    task automatic send_word(input logic [31:0] w, input logic last, input logic poke,
                             output logic accepted);
        int unsigned t;
        logic fits;
        t = 0;
        accepted = 1'b0;
        wdata = w;
        wlast = last;
        wvalid = 1'b1;
        while (!wready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!wready) begin
            chk("wready_timeout", 32'd0, 32'd1);
            wvalid = 1'b0;
            return;
        end
        fits = (longint'(m_ptr) + 64'd3) <= longint'(D - 1);
        RAdrs = m_ptr;
        @(posedge clk);
        #1;
        wvalid = 1'b0;
        wdata = $urandom;
        wlast = 1'($urandom);
        if (!fits) begin
            @(negedge clk);
            chk("ovf_err", {31'd0, err}, 32'd1);
            chk("ovf_busy", {31'd0, busy}, 32'd0);
            chk("ovf_wready", {31'd0, wready}, 32'd0);
            chk("ovf_done", {31'd0, done}, 32'd0);
            @(negedge clk);
            chk("ovf_done2", {31'd0, done}, 32'd0);
            return;
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (poke && k == 1) begin
                start = 1'b1;
                base_adrs = $urandom_range(0, 300);
            end
            if (poke && k == 2) start = 1'b0;
            chk("wr_busy", {31'd0, busy}, 32'd1);
            chk("wr_wready", {31'd0, wready}, 32'd0);
            chk("wr_itm", ITM, exp_itm(m_ptr));
            mdl[m_ptr + 32'(k)] = w[31-8*k -: 8];
        end
        @(negedge clk);
        chk("wr_itm_full", ITM, exp_itm(m_ptr));
        m_ptr = m_ptr + 32'd4;
        if (last) begin
            chk("done_pulse", {31'd0, done}, 32'd1);
            chk("done_wready", {31'd0, wready}, 32'd0);
            @(negedge clk);
            chk("done_fall", {31'd0, done}, 32'd0);
            chk("busy_fall", {31'd0, busy}, 32'd0);
        end else begin
            chk("next_wready", {31'd0, wready}, 32'd1);
            chk("next_done", {31'd0, done}, 32'd0);
        end
        accepted = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic acc;
        logic [31:0] words [3];
        int unsigned hs [$];
        int unsigned ndone;
        int unsigned idx;
        int unsigned nw;
        logic [31:0] b;

        for (int i = 0; i < int'(D); i++) mdl[i] = 8'h00;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_wready", {31'd0, wready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        rst_n = 1'b1;

        // Directed single word at base 0
        do_start(32'd0);
        send_word(32'h8C010004, 1'b1, 1'b0, acc);
        read_chk("itm0", 32'd0);
        chk("itm0_const", ITM, 32'h8C010004);

        // Fill the whole memory with random words so every model byte is known
        do_start(32'd0);
        for (int i = 0; i < int'(D / 4); i++) send_word($urandom, i == int'(D / 4) - 1, 1'b0, acc);
        chk("fill_ptr", m_ptr, D);

        // Back-to-back words with wvalid held high
        words[0] = 32'h11223344; words[1] = 32'h55667788; words[2] = 32'h99AABBCC;
        do_start(32'd8);
        idx = 0; ndone = 0;
        wdata = words[0]; wlast = 1'b0; wvalid = 1'b1;
        for (int unsigned c = 0; c < 25; c++) begin
            logic hit;
            hit = wready && wvalid;
            if (wready) hs.push_back(c);
            if (done) ndone++;
            @(posedge clk);
            #1;
            if (hit) begin
                idx++;
                if (idx < 3) begin
                    wdata = words[idx];
                    wlast = (idx == 2);
                end else begin
                    wvalid = 1'b0;
                end
            end
            @(negedge clk);
        end
        wvalid = 1'b0;
        for (int w = 0; w < 3; w++)
            for (int k = 0; k < 4; k++) mdl[8 + 4*w + k] = words[w][31-8*k -: 8];
        chk("b2b_count", hs.size(), 32'd3);
        if (hs.size() == 3) begin
            chk("b2b_gap1", hs[1] - hs[0], 32'd5);
            chk("b2b_gap2", hs[2] - hs[0], 32'd10);
        end
        chk("b2b_done", ndone, 32'd1);
        read_chk("b2b_itm12", 32'd12);
        chk("b2b_itm12_const", ITM, 32'h55667788);
        read_chk("b2b_itm8", 32'd8);

        // Overflow at the top of memory
        do_start(32'd396);
        send_word($urandom, 1'b0, 1'b0, acc);
        chk("ovf_first_acc", {31'd0, acc}, 32'd1);
        send_word(32'hA5A5A5A5, 1'b1, 1'b0, acc);
        chk("ovf_second_acc", {31'd0, acc}, 32'd0);
        read_chk("itm398", 32'd398);
        chk("itm398_const", ITM, {mdl[398], mdl[399], 16'h0000});
        read_chk("itm400", 32'd400);
        repeat (3) @(negedge clk);
        chk("err_sticky", {31'd0, err}, 32'd1);
        chk("ovf_no_done", {31'd0, done}, 32'd0);

        // Pointer near 2^32 must not wrap past the check; start clears err first
        do_start(32'hFFFF_FFFE);
        send_word($urandom, 1'b1, 1'b0, acc);
        chk("wrap_rejected", {31'd0, acc}, 32'd0);

        // Stray start during WRITE; the following start in IDLE clears err
        do_start(32'd100);
        send_word($urandom, 1'b0, 1'b1, acc);
        send_word($urandom, 1'b1, 1'b0, acc);
        read_chk("poke_itm100", 32'd100);
        read_chk("poke_itm104", 32'd104);

        // Reset after the second byte of a word
        do_start(32'd20);
        wdata = 32'hDEADBEEF; wlast = 1'b1; wvalid = 1'b1;
        @(posedge clk);
        #1 wvalid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        mdl[20] = 8'hDE;
        mdl[21] = 8'hAD;
        RAdrs = 32'd20;
        #1;
        chk("mid_rst_itm20", ITM, exp_itm(32'd20));
        chk("mid_rst_wready", {31'd0, wready}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        read_chk("post_rst_itm20", 32'd20);

        // Randomized loads, some running off the end of memory
        for (int it = 0; it < 25; it++) begin
            b = $urandom_range(0, D + 10);
            nw = $urandom_range(1, 3);
            do_start(b);
            for (int unsigned w = 0; w < nw; w++) begin
                int unsigned gap;
                gap = $urandom_range(0, 2);
                repeat (gap) @(negedge clk);
                send_word($urandom, w == nw - 1, 1'b0, acc);
                if (!acc) break;
            end
            for (int r = 0; r < 4; r++) read_chk("rnd_itm", $urandom_range(0, D + 5));
            read_chk("rnd_itm_base", b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-addressed instruction memory with an in-system write path. Host words arrive over a valid/ready handshake and are split into four big-endian byte writes, MSB byte at the lowest address, so the memory can be filled without a preload file. The combinational instruction-fetch read port (`RAdrs` → `ITM`) is kept unchanged so the datapath sees the same contents the loader wrote. Sits between the test/boot host and the fetch stage.

## Interface
- `DEPTH`, 400: memory size in bytes.
- `clk` in 1: single clock; all writes and state changes occur on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that arms a load at `base_adrs`; honoured only in IDLE.
- `base_adrs` in 32: byte address of the first word, sampled with `start`.
- `wdata` in 32: word to store.
- `wvalid` in 1: `wdata`/`wlast` are valid.
- `wlast` in 1: the current word is the final word of the load.
- `wready` out 1: loader accepts a word this cycle.
- `busy` out 1: state is not IDLE.
- `done` out 1: one-cycle pulse after the final byte of a `wlast` word is written.
- `err` out 1: sticky overflow flag, cleared by the next accepted `start`.
- `RAdrs` in 32: fetch byte address.
- `ITM` out 32: `{M[RAdrs], M[RAdrs+1], M[RAdrs+2], M[RAdrs+3]}`, combinational.

## Operation
- States: IDLE, ARMED, WRITE, DONE.
- IDLE, `start`=1: pointer ← `base_adrs`, `err` ← 0, go to ARMED.
- ARMED: `wready`=1. A handshake is `wvalid & wready`.
  - If pointer+3 ≤ DEPTH−1: latch `wdata` and `wlast`, clear the byte counter, go to WRITE.
  - Otherwise: drop the word, set `err`, go to IDLE; `done` does not pulse.
- WRITE: byte counter k = 0..3 writes `word[31−8k -: 8]` to M[pointer+k], one byte per cycle.
  - After k=3: pointer += 4.
  - If the latched `wlast`=1, go to DONE; otherwise go to ARMED.
- DONE: `done`=1 for one cycle, then IDLE.
- `start` outside IDLE is ignored. `wvalid` outside ARMED is ignored, since `wready`=0 there.
- Pointer arithmetic is 32-bit unsigned. The overflow check is done in 33 bits so that pointer values near 2^32 cannot wrap and pass.
- Read port: any byte address ≥ DEPTH reads 8'h00, per byte (a partially out-of-range word returns its in-range bytes and zeros).
- Read during write: `ITM` reflects a byte from the edge on which it is written onward. No bypass of latched, unwritten bytes.
- Memory contents are never cleared by reset. In simulation the initial contents are all zero.

## Timing
- Reset values: state IDLE, pointer 0, byte counter 0, `wready`=0, `busy`=0, `done`=0, `err`=0.
- Reset mid-load returns to IDLE immediately. Bytes already written stay; the remaining bytes of the latched word are not written.
- Handshake on edge E0 → bytes written on edges E1, E2, E3, E4.
- After E4, `wready`=1 again (non-last word) or `done`=1 (last word) in the cycle following E4.
- Throughput is 1 word per 5 cycles. `busy` falls the cycle after `done`.
- An overflowing handshake on E0 gives `err`=1 and `busy`=0 from E0 onward.
- `ITM` has zero-cycle latency from `RAdrs`.

## Structure
- Package `imem_pkg`:
  - state enum (IDLE, ARMED, WRITE, DONE)
  - `IMEM_DEPTH`=400
  - `BYTE_W`=8
  - `WORD_BYTES`=4
- Sub-module `imem_byte_ram`:
  - DEPTH×8 array
  - single synchronous byte write port (`we`, `wadrs`, `wbyte`)
  - four combinational byte reads with out-of-range → 0
  - `imem_loader` instantiates it and holds the FSM, pointer and counter.

## Test plan
- Reset, then `start` with base 0, then one word 32'h8C010004 with `wlast`=1. Required: M[0..3] = 8C,01,00,04; `ITM`@0 = 32'h8C010004; `done` pulses at cycle E0+5.
- Three back-to-back words (11223344, 55667788, 99AABBCC, last on the third) at base 8, with `wvalid` held high. Required: `wready` high exactly at E0, E0+5, E0+10; `ITM`@12 = 32'h55667788; one `done` pulse.
- Base 396, two words. Required: first word written to 396..399; second word rejected, `err`=1, `done` never asserts, M unchanged past 399. `ITM`@398 = {M[398], M[399], 00, 00}.
- `rst_n` low after byte 1 of word 32'hDEADBEEF at base 20. Required: M[20]=DE and M[21]=AD; M[22..23] keep their previous value; all outputs are at reset values.
- A `start` pulse while in WRITE is ignored: the pointer is unchanged and the load completes at the original addresses. A following `start` in IDLE clears `err`.
